// File: rtl/rd_path_pkg.sv
// Shared read-path types and constants: FSM encoding, skip counter width, DQ word width.
package rd_path_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SKIP = 2'd1,
    DATA = 2'd2,
    DONE = 2'd3
  } rd_state_e;

  localparam int SKIP_CNT_W = 4;
  localparam int DQ_WORD_W  = 16;

endpackage

// File: rtl/dqs_rx_wordcnt.sv
// Word counter with synchronous clear/enable and a terminal compare on the next increment.
// last_o is combinational: high when one more increment makes count equal limit_i.
module dqs_rx_wordcnt #(
  parameter int W = 11
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         clr_i,
  input  logic         en_i,
  input  logic [W-1:0] limit_i,
  output logic [W-1:0] count_o,
  output logic         last_o
);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i) begin
      cnt_d = cnt_q + W'(1);
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign count_o = cnt_q;
  assign last_o  = ((cnt_q + W'(1)) == limit_i);

endmodule

// File: rtl/dqs_rx_capture.sv
// DQS-domain read capture: drops SKIP_BEATS preamble edges, then writes data_len+1 words to the FIFO.
// Optional DQS_RX_CHECKSUM_EN adds rx_csum, a running XOR of all written words.
module dqs_rx_capture
  import rd_path_pkg::*;
#(
  parameter int MEM_LEN    = 9,
  parameter int SKIP_BEATS = 0
) (
  input  logic                 dqs_clk,
  input  logic                 rst_ce,
  input  logic                 read_state,
  input  logic [MEM_LEN:0]     data_len,
  input  logic [7:0]           dq_rise,
  input  logic [7:0]           dq_fall,
  output logic                 wr_en,
  output logic [DQ_WORD_W-1:0] wr_data,
  output logic [MEM_LEN+1:0]   word_count,
  output logic                 burst_done,
  output logic                 overrun
`ifdef DQS_RX_CHECKSUM_EN
  ,output logic [DQ_WORD_W-1:0] rx_csum
`endif
);

  localparam int CW = MEM_LEN + 2;
  localparam logic [SKIP_CNT_W-1:0] SKIP_LIM = SKIP_CNT_W'(SKIP_BEATS);

  rd_state_e             state_q, state_d;
  logic [SKIP_CNT_W-1:0] skip_q, skip_d;
  logic                  wr_en_q, wr_en_d;
  logic [DQ_WORD_W-1:0]  wr_data_q, wr_data_d;
  logic                  done_q, done_d;
  logic                  ovr_q, ovr_d;
  logic                  capture;
  logic                  cnt_clr;
  logic                  cnt_last;
  logic [CW-1:0]         cnt_limit;
  logic [CW-1:0]         cnt_val;

  // One extra bit so an all-ones data_len still yields a non-wrapping word total.
  assign cnt_limit = {1'b0, data_len} + CW'(1);

  dqs_rx_wordcnt #(
    .W (CW)
  ) u_wordcnt (
    .clk_i   (dqs_clk),
    .rst_i   (rst_ce),
    .clr_i   (cnt_clr),
    .en_i    (capture),
    .limit_i (cnt_limit),
    .count_o (cnt_val),
    .last_o  (cnt_last)
  );

  always_comb begin
    state_d   = state_q;
    skip_d    = skip_q;
    wr_en_d   = 1'b0;
    wr_data_d = wr_data_q;
    done_d    = done_q;
    ovr_d     = ovr_q;
    capture   = 1'b0;
    cnt_clr   = 1'b0;

    if (!read_state) begin
      state_d = IDLE;
      skip_d  = '0;
      done_d  = 1'b0;
      ovr_d   = 1'b0;
      cnt_clr = 1'b1;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (SKIP_LIM != '0) begin
            // The edge leaving IDLE is itself the first discarded beat.
            skip_d  = SKIP_CNT_W'(1);
            state_d = (SKIP_LIM == SKIP_CNT_W'(1)) ? DATA : SKIP;
          end else begin
            capture = 1'b1;
          end
        end
        SKIP: begin
          skip_d = skip_q + SKIP_CNT_W'(1);
          if (skip_d == SKIP_LIM) begin
            state_d = DATA;
          end
        end
        DATA: capture = 1'b1;
        DONE: ovr_d = 1'b1;
        default: state_d = IDLE;
      endcase

      if (capture) begin
        wr_en_d   = 1'b1;
        wr_data_d = {dq_rise, dq_fall};
        state_d   = DATA;
        if (cnt_last) begin
          done_d  = 1'b1;
          state_d = DONE;
        end
      end
    end
  end

  always_ff @(posedge dqs_clk or posedge rst_ce) begin
    if (rst_ce) begin
      state_q   <= IDLE;
      skip_q    <= '0;
      wr_en_q   <= 1'b0;
      wr_data_q <= '0;
      done_q    <= 1'b0;
      ovr_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      skip_q    <= skip_d;
      wr_en_q   <= wr_en_d;
      wr_data_q <= wr_data_d;
      done_q    <= done_d;
      ovr_q     <= ovr_d;
    end
  end

  assign wr_en      = wr_en_q;
  assign wr_data    = wr_data_q;
  assign word_count = cnt_val;
  assign burst_done = done_q;
  assign overrun    = ovr_q;

`ifdef DQS_RX_CHECKSUM_EN
  logic [DQ_WORD_W-1:0] csum_q, csum_d;

  always_comb begin
    csum_d = csum_q;
    if (!read_state) begin
      csum_d = '0;
    end else if (capture) begin
      csum_d = csum_q ^ {dq_rise, dq_fall};
    end
  end

  always_ff @(posedge dqs_clk or posedge rst_ce) begin
    if (rst_ce) begin
      csum_q <= '0;
    end else begin
      csum_q <= csum_d;
    end
  end

  assign rx_csum = csum_q;
`endif

endmodule

// File: tb/tb_dqs_rx_capture.sv
// Bench for dqs_rx_capture: SKIP_BEATS=0 and SKIP_BEATS=2 instances share stimulus and are
// checked every edge against an edge-index model of the burst.
module tb_dqs_rx_capture;

  logic        dqs_clk = 1'b0;
  logic        rst_ce;
  logic        read_state;
  logic [9:0]  data_len;
  logic [7:0]  dq_rise;
  logic [7:0]  dq_fall;

  logic        wr_en0, bd0, ov0, wr_en2, bd2, ov2;
  logic [15:0] wr_data0, wr_data2;
  logic [10:0] wc0, wc2;
`ifdef DQS_RX_CHECKSUM_EN
  logic [15:0] rx_csum0, rx_csum2;
`endif

  logic [29:0] obs0, obs2, exp0, exp2;
  assign obs0 = {wr_en0, wr_data0, wc0, bd0, ov0};
  assign obs2 = {wr_en2, wr_data2, wc2, bd2, ov2};

  int checks   = 0;
  int failures = 0;
  int edges    = 0;
  logic [15:0] last0 = '0, last2 = '0, csum0 = '0, csum2 = '0;

  always #5 dqs_clk = ~dqs_clk;

  dqs_rx_capture #(.MEM_LEN(9), .SKIP_BEATS(0)) u_dut0 (
    .dqs_clk (dqs_clk), .rst_ce (rst_ce), .read_state (read_state), .data_len (data_len),
    .dq_rise (dq_rise), .dq_fall (dq_fall), .wr_en (wr_en0), .wr_data (wr_data0),
    .word_count (wc0), .burst_done (bd0), .overrun (ov0)
`ifdef DQS_RX_CHECKSUM_EN
    , .rx_csum (rx_csum0)
`endif
  );

  dqs_rx_capture #(.MEM_LEN(9), .SKIP_BEATS(2)) u_dut2 (
    .dqs_clk (dqs_clk), .rst_ce (rst_ce), .read_state (read_state), .data_len (data_len),
    .dq_rise (dq_rise), .dq_fall (dq_fall), .wr_en (wr_en2), .wr_data (wr_data2),
    .word_count (wc2), .burst_done (bd2), .overrun (ov2)
`ifdef DQS_RX_CHECKSUM_EN
    , .rx_csum (rx_csum2)
`endif
  );

  // Edge e (1-based, counted since read_state rose) writes word e-s when s < e <= s+n.
  function automatic logic writes(input int s);
    int n = int'(data_len) + 1;
    return (edges > s) && (edges <= s + n);
  endfunction

  function automatic logic [29:0] expv(input int s, input logic [15:0] last);
    int n = int'(data_len) + 1;
    int wc;
    wc = (edges <= s) ? 0 : ((edges - s > n) ? n : edges - s);
    return {writes(s), last, 11'(wc), edges >= s + n, edges > s + n};
  endfunction

  function automatic void model_reset();
    edges = 0; last0 = '0; last2 = '0; csum0 = '0; csum2 = '0;
    exp0 = expv(0, last0); exp2 = expv(2, last2);
  endfunction

  task automatic step(input logic rs, input logic [7:0] r, input logic [7:0] f);
    @(negedge dqs_clk);
    read_state = rs; dq_rise = r; dq_fall = f;
    @(posedge dqs_clk);
    #1;
    if (!rs) begin
      edges = 0; csum0 = '0; csum2 = '0;
    end else begin
      edges++;
      if (writes(0)) begin last0 = {r, f}; csum0 ^= {r, f}; end
      if (writes(2)) begin last2 = {r, f}; csum2 ^= {r, f}; end
    end
    exp0 = expv(0, last0);
    exp2 = expv(2, last2);
  endtask

  task automatic start_burst(input logic [9:0] dl);
    step(1'b0, 8'h00, 8'h00);
    data_len = dl;
  endtask

  task automatic test_reset();
    rst_ce = 1'b1; read_state = 1'b0; data_len = '0; dq_rise = '0; dq_fall = '0;
    model_reset();
    #3;
    checks += 2;
    if (obs0 !== 30'd0) begin failures++; $display("FAIL reset dut0: got %h want %h", obs0, 30'd0); end
    if (obs2 !== 30'd0) begin failures++; $display("FAIL reset dut2: got %h want %h", obs2, 30'd0); end
    repeat (2) @(negedge dqs_clk);
    rst_ce = 1'b0;
  endtask

  task automatic test_basic();
    logic [7:0] ra [4] = '{8'hA1, 8'hA2, 8'hA3, 8'hA4};
    logic [7:0] fa [4] = '{8'hB1, 8'hB2, 8'hB3, 8'hB4};
    start_burst(10'd3);
    for (int i = 0; i < 6; i++) begin
      step(1'b1, ra[i % 4], fa[i % 4]);
      checks += 2;
      if (obs0 !== exp0) begin failures++; $display("FAIL basic dut0 e%0d: got %h want %h", edges, obs0, exp0); end
      if (obs2 !== exp2) begin failures++; $display("FAIL basic dut2 e%0d: got %h want %h", edges, obs2, exp2); end
      if (i == 3) begin
        checks++;
        if ({wr_en0, wr_data0, wc0, bd0} !== {1'b1, 16'hA4B4, 11'd4, 1'b1}) begin
          failures++; $display("FAIL basic_last dut0: got %h want %h", {wr_en0, wr_data0, wc0, bd0}, {1'b1, 16'hA4B4, 11'd4, 1'b1});
        end
      end
    end
  endtask

  task automatic test_skip();
    start_burst(10'd0);
    for (int i = 0; i < 3; i++) begin
      step(1'b1, 8'($urandom), 8'($urandom));
      checks += 2;
      if (obs0 !== exp0) begin failures++; $display("FAIL skip dut0 e%0d: got %h want %h", edges, obs0, exp0); end
      if (obs2 !== exp2) begin failures++; $display("FAIL skip dut2 e%0d: got %h want %h", edges, obs2, exp2); end
    end
  endtask

  task automatic test_overrun();
    start_burst(10'd1);
    for (int i = 0; i < 5; i++) begin
      step(1'b1, 8'($urandom), 8'($urandom));
      checks += 2;
      if (obs0 !== exp0) begin failures++; $display("FAIL overrun dut0 e%0d: got %h want %h", edges, obs0, exp0); end
      if (obs2 !== exp2) begin failures++; $display("FAIL overrun dut2 e%0d: got %h want %h", edges, obs2, exp2); end
    end
  endtask

  task automatic test_reset_mid();
    start_burst(10'd7);
    for (int i = 0; i < 2; i++) step(1'b1, 8'($urandom), 8'($urandom));
    #2 rst_ce = 1'b1;
    model_reset();
    #1;
    checks += 2;
    if (obs0 !== 30'd0) begin failures++; $display("FAIL reset_mid dut0: got %h want %h", obs0, 30'd0); end
    if (obs2 !== 30'd0) begin failures++; $display("FAIL reset_mid dut2: got %h want %h", obs2, 30'd0); end
    rst_ce = 1'b0;
    for (int i = 0; i < 11; i++) begin
      step(1'b1, 8'($urandom), 8'($urandom));
      checks += 2;
      if (obs0 !== exp0) begin failures++; $display("FAIL restart dut0 e%0d: got %h want %h", edges, obs0, exp0); end
      if (obs2 !== exp2) begin failures++; $display("FAIL restart dut2 e%0d: got %h want %h", edges, obs2, exp2); end
    end
  endtask

  task automatic test_simul_fall();
    start_burst(10'd3);
    for (int i = 0; i < 3; i++) step(1'b1, 8'($urandom), 8'($urandom));
    step(1'b0, 8'h5A, 8'hA5);
    checks += 3;
    if (obs0 !== exp0) begin failures++; $display("FAIL simul_fall dut0: got %h want %h", obs0, exp0); end
    if (obs2 !== exp2) begin failures++; $display("FAIL simul_fall dut2: got %h want %h", obs2, exp2); end
    if ({wr_en0, bd0} !== 2'b00) begin failures++; $display("FAIL simul_fall_flags dut0: got %b want %b", {wr_en0, bd0}, 2'b00); end
  endtask

  task automatic test_random();
    for (int b = 0; b < 8; b++) begin
      int dl = $urandom_range(0, 12);
      int ne = $urandom_range(0, dl + 6);
      start_burst(10'(dl));
      for (int i = 0; i < ne; i++) begin
        step(1'b1, 8'($urandom), 8'($urandom));
        checks += 2;
        if (obs0 !== exp0) begin failures++; $display("FAIL random dut0 b%0d e%0d: got %h want %h", b, edges, obs0, exp0); end
        if (obs2 !== exp2) begin failures++; $display("FAIL random dut2 b%0d e%0d: got %h want %h", b, edges, obs2, exp2); end
      end
    end
  endtask

  task automatic test_max_len();
    int nwr = 0;
    start_burst(10'h3FF);
    for (int i = 0; i < 1026; i++) begin
      step(1'b1, 8'($urandom), 8'($urandom));
      if (wr_en0) nwr++;
      checks += 2;
      if (obs0 !== exp0) begin failures++; $display("FAIL max_len dut0 e%0d: got %h want %h", edges, obs0, exp0); end
      if (obs2 !== exp2) begin failures++; $display("FAIL max_len dut2 e%0d: got %h want %h", edges, obs2, exp2); end
    end
    checks += 2;
    if (nwr != 1024) begin failures++; $display("FAIL max_len_writes: got %0d want %0d", nwr, 1024); end
    if (wc0 !== 11'd1024) begin failures++; $display("FAIL max_len_count: got %0d want %0d", wc0, 1024); end
  endtask

`ifdef DQS_RX_CHECKSUM_EN
  task automatic test_checksum();
    start_burst(10'd1);
    step(1'b1, 8'h12, 8'h34);
    step(1'b1, 8'h00, 8'hFF);
    step(1'b1, 8'h77, 8'h88);
    checks += 2;
    if (rx_csum0 !== 16'h12CB) begin failures++; $display("FAIL csum dut0: got %h want %h", rx_csum0, 16'h12CB); end
    if (rx_csum2 !== csum2) begin failures++; $display("FAIL csum dut2: got %h want %h", rx_csum2, csum2); end
    step(1'b0, 8'h00, 8'h00);
    checks++;
    if (rx_csum0 !== 16'h0000) begin failures++; $display("FAIL csum_clear dut0: got %h want %h", rx_csum0, 16'h0000); end
  endtask
`endif

  initial begin
    test_reset();
    test_basic();
    test_skip();
    test_overrun();
    test_reset_mid();
    test_simul_fall();
    test_random();
    test_max_len();
`ifdef DQS_RX_CHECKSUM_EN
    test_checksum();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
